muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS CPU datapath.
- Sits directly downstream of the register file. It consumes busA ($rs) and busB ($rt).
- It produces HI/LO values that MFHI/MFLO return to the register-file write bus.
- Handles MULT, MULTU, DIV, DIVU, MTHI, MTLO. Raises a stall to the controller while busy and a HI/LO read is requested.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- start  input  1  request to begin the operation given by op.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored).
- busA  input  WIDTH  $rs operand from the register file.
- busB  input  WIDTH  $rt operand from the register file.
- rd_req  input  1  controller is issuing MFHI/MFLO this cycle.
- hi  output  WIDTH  HI register, continuously driven.
- lo  output  WIDTH  LO register, continuously driven.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse on the edge HI/LO receive a mult/div result.
- stall  output  1  busy & rd_req, combinational.
- divz  output  1  divide-by-zero flag; exists only with MULDIV_DIVZERO_EN.

Behaviour:
- Reset (rst==0 at a posedge) applies regardless of state, including mid-operation:
  - state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, divz=0.
  - Any in-flight result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 32 iterations.
  - FIN: busy=1, sign fix-up and writeback.
- Accept: at a posedge with state==IDLE and start==1.
  - MTHI: hi<=busA. MTLO: lo<=busA. State stays IDLE, done stays 0; the new value is visible the next cycle.
  - MULT/MULTU/DIV/DIVU:
    - Latch the operation and operand magnitudes; signed ops take the absolute value.
    - Latch the operand sign bits.
    - Clear the accumulator, set counter=0, go to RUN.
  - Reserved op: ignored.
- A start while busy is ignored. The controller must stall issue.
- RUN: one iteration per edge.
  - Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
  - Divide: restoring algorithm, one quotient bit per cycle.
  - When counter==WIDTH-1, go to FIN; otherwise counter+1.
- FIN edge:
  - Product is negated if signed and the operand signs differ. hi<=product[63:32], lo<=product[31:0].
  - Quotient is negated if signed and the signs differ. Remainder takes the dividend's sign. lo<=quotient, hi<=remainder.
  - done<=1 for exactly one cycle; state<=IDLE.
- Latency: from the accept edge N, the new hi/lo and done are visible after edge N+33. busy is high for cycles N+1..N+33. A new start is accepted at edge N+34 or later.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (falls out of the magnitude path; must not be special-cased wrongly).
- Divide by zero without the macro:
  - Runs the full 33 cycles.
  - Result: quotient magnitude = all ones, remainder = dividend magnitude, then the sign fix-up above.
- hi/lo never change outside accept (MTHI/MTLO), FIN, or reset.

Optional Feature:
- Macro: MULDIV_DIVZERO_EN.
- Defined:
  - DIV/DIVU with busB==0 at accept skips RUN and goes straight to FIN.
  - At FIN: hi<=busA as latched (dividend, raw), lo<=all ones, done=1, divz=1 for that one cycle.
  - Latency becomes 2 cycles.
- Undefined: the divz port is absent; divide by zero follows the normal 33-cycle path.

Decomposition:
- Shared package (mips_pkg):
  - op encodings OP_MULT..OP_MTLO.
  - state encodings S_IDLE/S_RUN/S_FIN.
  - WIDTH default.
- Sub-module md_core: combinational one-iteration step for both multiply and divide, selected by a mode bit.
  - Inputs: accumulator, operand.
  - Outputs: next accumulator.
  - The top level owns the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULTU: 0xFFFFFFFF x 0xFFFFFFFF, start at cycle 0 → done after edge 33, hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- MULT: -7 (0xFFFFFFF9) x 6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6. DIV: -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU: 100 / 7 → lo=14, hi=2. DIV: 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0, back-to-back while idle → hi/lo update on the following cycles, busy and done stay 0. A start issued at cycle 10 of a MULT is ignored and the original result is intact. rd_req during busy → stall=1; after done, rd_req → stall=0.
- Mid-operation reset: start DIVU 50/5, drive rst=0 at cycle 15 → next edge busy=0, hi=lo=0, no done pulse. A subsequent MULTU 3x4 → lo=12, hi=0.
- DIVU 9/0:
  - With MULDIV_DIVZERO_EN: done and divz at edge 2, hi=9, lo=0xFFFFFFFF.
  - Without: done at edge 33, lo=0xFFFFFFFF, hi=9.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
// The package holds the operation codes, the FSM state codes and the default operand width.
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  // Operation codes on the op port. 110 and 111 are reserved.
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // FSM state codes.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result interface between the controller and the multiply/divide unit.
// The divz flag exists only when MULDIV_DIVZERO_EN is defined.
interface muldiv_unit_if #(parameter int WIDTH = mips_pkg::WIDTH_DEF);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             rd_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
`ifdef MULDIV_DIVZERO_EN
  logic             divz;
`endif

  // Controller side: issues operations, observes HI/LO and status.
  modport master (
    output start, op, busA, busB, rd_req,
`ifdef MULDIV_DIVZERO_EN
    input  divz,
`endif
    input  hi, lo, busy, done, stall
  );

  // Unit side.
  modport slave (
    input  start, op, busA, busB, rd_req,
`ifdef MULDIV_DIVZERO_EN
    output divz,
`endif
    output hi, lo, busy, done, stall
  );

endinterface

// File: rtl/muldiv_unit_core.sv
// md_core: one combinational iteration of shift-add multiply or restoring divide.
// The accumulator is {upper, lower}. Multiply keeps the multiplier in the lower half and
// shifts it out LSB first. Divide keeps the dividend in the lower half, shifts it into the
// partial remainder MSB first, and collects quotient bits in the vacated LSBs.
module md_core #(
  parameter int WIDTH = 32
) (
  input  logic               mode,     // 0 = multiply, 1 = divide
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opd,      // multiplicand or divisor magnitude
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             borrow;
  logic [WIDTH-1:0] rem_sub;

  // Multiply: conditionally add the multiplicand to the upper half and keep the carry.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});

  // Divide: bring the next dividend bit into the remainder, then trial-subtract.
  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign borrow  = rem_sh < {1'b0, opd};
  assign rem_sub = rem_sh[WIDTH-1:0] - opd;

  // Select the step result for the active mode.
  always_comb begin
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (mode) begin
      if (borrow) acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else        acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO.
// Optional feature: defining MULDIV_DIVZERO_EN makes a zero divisor finish early and
// raise the divz flag.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opd_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               div_reg;
  logic               sgn_reg;
  logic               sa_reg;
  logic               sb_reg;
  logic               done_reg;
`ifdef MULDIV_DIVZERO_EN
  logic               dz_reg;
  logic               divz_reg;
  logic [WIDTH-1:0]   raw_a_reg;
`endif

  logic               op_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  md_core #(.WIDTH(WIDTH)) u_core (
    .mode     (div_reg),
    .acc      (acc_reg),
    .opd      (opd_reg),
    .acc_next (acc_step)
  );

  // Operand magnitudes at accept. Signed ops take the absolute value; 0x80000000 maps to itself.
  assign op_signed = ~bus.op[0];
  assign abs_a = (op_signed && bus.busA[WIDTH-1]) ? -bus.busA : bus.busA;
  assign abs_b = (op_signed && bus.busB[WIDTH-1]) ? -bus.busB : bus.busB;

  // Sign fix-up of the magnitude results. The remainder follows the dividend's sign.
  assign res_neg = sgn_reg & (sa_reg ^ sb_reg);
  assign prod    = res_neg ? -acc_reg : acc_reg;
  assign quo     = res_neg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem     = (sgn_reg & sa_reg) ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.busy  = (state_reg != S_IDLE);
  assign bus.done  = done_reg;
  assign bus.stall = bus.busy & bus.rd_req;
`ifdef MULDIV_DIVZERO_EN
  assign bus.divz  = divz_reg;
`endif

  // FSM, iteration counter, accumulator and HI/LO writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      opd_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      div_reg   <= 1'b0;
      sgn_reg   <= 1'b0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      done_reg  <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_reg    <= 1'b0;
      divz_reg  <= 1'b0;
      raw_a_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      divz_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MTHI) begin
              hi_reg <= bus.busA;
            end else if (bus.op == OP_MTLO) begin
              lo_reg <= bus.busA;
            end else if (!bus.op[2]) begin
              div_reg   <= bus.op[1];
              sgn_reg   <= op_signed;
              sa_reg    <= bus.busA[WIDTH-1];
              sb_reg    <= bus.busB[WIDTH-1];
              acc_reg   <= {{WIDTH{1'b0}}, abs_a};
              opd_reg   <= abs_b;
              cnt_reg   <= '0;
              state_reg <= S_RUN;
`ifdef MULDIV_DIVZERO_EN
              raw_a_reg <= bus.busA;
              dz_reg    <= bus.op[1] && (bus.busB == '0);
              // A zero divisor spends a single cycle in RUN, then writes back at FIN.
              if (bus.op[1] && (bus.busB == '0)) cnt_reg <= {CNT_W{1'b1}};
`endif
            end
          end
        end
        S_RUN: begin
          acc_reg <= acc_step;
          if (cnt_reg == {CNT_W{1'b1}}) state_reg <= S_FIN;
          else                          cnt_reg   <= cnt_reg + 1'b1;
        end
        S_FIN: begin
          if (div_reg) begin
            lo_reg <= quo;
            hi_reg <= rem;
          end else begin
            hi_reg <= prod[2*WIDTH-1:WIDTH];
            lo_reg <= prod[WIDTH-1:0];
          end
`ifdef MULDIV_DIVZERO_EN
          if (dz_reg) begin
            hi_reg   <= raw_a_reg;
            lo_reg   <= '1;
            divz_reg <= 1'b1;
          end
          dz_reg <= 1'b0;
`endif
          done_reg  <= 1'b1;
          cnt_reg   <= '0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs are driven 1 ns after each rising edge and outputs are sampled at the same point.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_unit_if bus_if ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div and wait for done (bounded). lat counts edges after the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_low);
    bus_if.start = 1'b1;
    bus_if.op    = o;
    bus_if.busA  = a;
    bus_if.busB  = b;
    step();
    bus_if.start = 1'b0;
    lat      = 0;
    busy_low = 0;
    while (lat < 60) begin
      if (bus_if.busy !== 1'b1) busy_low++;
      step();
      lat++;
      if (bus_if.done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.rd_req = 1'b1;
    repeat (3) step();
    checks++;
    if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", bus_if.hi, bus_if.lo);
    end
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b stall=%b expected 0/0/0",
               bus_if.busy, bus_if.done, bus_if.stall);
    end
    bus_if.rd_req = 1'b0;
    rst = 1'b1;
    step();
    $display("[reset] hi=%h lo=%h busy=%b", bus_if.hi, bus_if.lo, bus_if.busy);
  endtask

  // Generic arithmetic check: latency, busy coverage, result, and single-cycle done.
  task automatic test_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input int exp_lat);
    int lat;
    int busy_low;
    run_op(o, a, b, lat, busy_low);
    $display("[%s] a=%h b=%h hi=%h lo=%h lat=%0d", name, a, b, bus_if.hi, bus_if.lo, lat);
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_low != 0) begin
      failures++;
      $display("FAIL %s_busy: busy low for %0d cycles expected 0", name, busy_low);
    end
    checks++;
    if (bus_if.hi !== exp_hi || bus_if.lo !== exp_lo) begin
      failures++;
      $display("FAIL %s_result: hi=%h lo=%h expected hi=%h lo=%h",
               name, bus_if.hi, bus_if.lo, exp_hi, exp_lo);
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b expected 0 after done", name, bus_if.busy);
    end
    step();
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.hi !== exp_hi || bus_if.lo !== exp_lo) begin
      failures++;
      $display("FAIL %s_pulse: done=%b hi=%h lo=%h expected done=0 and result held",
               name, bus_if.done, bus_if.hi, bus_if.lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    bus_if.start = 1'b1;
    bus_if.op    = 3'b100;
    bus_if.busA  = 32'h12345678;
    step();
    checks++;
    if (bus_if.hi !== 32'h12345678 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h busy=%b done=%b expected 12345678/0/0",
               bus_if.hi, bus_if.busy, bus_if.done);
    end
    bus_if.op   = 3'b101;
    bus_if.busA = 32'h9ABCDEF0;
    step();
    bus_if.start = 1'b0;
    checks++;
    if (bus_if.lo !== 32'h9ABCDEF0 || bus_if.hi !== 32'h12345678 ||
        bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b expected 12345678/9abcdef0/0/0",
               bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done);
    end
    // Reserved op must leave HI/LO alone and not start anything.
    bus_if.start = 1'b1;
    bus_if.op    = 3'b110;
    bus_if.busA  = 32'hDEADBEEF;
    step();
    bus_if.start = 1'b0;
    checks++;
    if (bus_if.hi !== 32'h12345678 || bus_if.lo !== 32'h9ABCDEF0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL reserved_op: hi=%h lo=%h busy=%b expected unchanged and idle",
               bus_if.hi, bus_if.lo, bus_if.busy);
    end
    $display("[mthi_mtlo] hi=%h lo=%h", bus_if.hi, bus_if.lo);
  endtask

  // MULT 3x5 with a conflicting start at cycle 10 and MFHI/MFLO requests for stall.
  task automatic test_start_while_busy();
    int lat;
    logic saw_stall;
    logic hold_ok;
    bus_if.start = 1'b1;
    bus_if.op    = 3'b000;
    bus_if.busA  = 32'd3;
    bus_if.busB  = 32'd5;
    step();
    bus_if.start = 1'b0;
    lat       = 0;
    saw_stall = 1'b0;
    hold_ok   = 1'b1;
    while (lat < 60) begin
      bus_if.start = (lat == 9);
      bus_if.op    = 3'b001;
      bus_if.busA  = 32'd7;
      bus_if.busB  = 32'd7;
      bus_if.rd_req = (lat == 5);
      #1;
      if (lat == 5 && bus_if.stall === 1'b1) saw_stall = 1'b1;
      if (bus_if.hi !== 32'h12345678 || bus_if.lo !== 32'h9ABCDEF0) hold_ok = 1'b0;
      step();
      lat++;
      if (bus_if.done === 1'b1) break;
    end
    bus_if.start  = 1'b0;
    bus_if.rd_req = 1'b1;
    #1;
    $display("[start_while_busy] hi=%h lo=%h lat=%0d", bus_if.hi, bus_if.lo, lat);
    checks++;
    if (lat != 33 || bus_if.lo !== 32'd15 || bus_if.hi !== 32'd0) begin
      failures++;
      $display("FAIL busy_start: lat=%0d hi=%h lo=%h expected 33/0/0000000f",
               lat, bus_if.hi, bus_if.lo);
    end
    checks++;
    if (!saw_stall) begin
      failures++;
      $display("FAIL stall_busy: stall=0 during busy rd_req expected 1");
    end
    checks++;
    if (bus_if.stall !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle: stall=%b after done expected 0", bus_if.stall);
    end
    checks++;
    if (!hold_ok) begin
      failures++;
      $display("FAIL hilo_hold: hi/lo changed mid-operation expected 12345678/9abcdef0");
    end
    bus_if.rd_req = 1'b0;
    repeat (3) step();
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_dropped: busy=%b expected 0 (ignored start)", bus_if.busy);
    end
  endtask

  task automatic test_mid_reset();
    bus_if.start = 1'b1;
    bus_if.op    = 3'b011;
    bus_if.busA  = 32'd50;
    bus_if.busB  = 32'd5;
    step();
    bus_if.start = 1'b0;
    repeat (14) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    $display("[mid_reset] busy=%b hi=%h lo=%h done=%b", bus_if.busy, bus_if.hi, bus_if.lo,
             bus_if.done);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0 ||
        bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b hi=%h lo=%h done=%b expected 0/0/0/0",
               bus_if.busy, bus_if.hi, bus_if.lo, bus_if.done);
    end
    repeat (40) begin
      step();
      checks++;
      if (bus_if.done !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_nodone: done=%b expected 0", bus_if.done);
      end
    end
    test_arith("multu_after_reset", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 33);
  endtask

  task automatic test_divzero();
`ifdef MULDIV_DIVZERO_EN
    int lat;
    int busy_low;
    logic divz_at_done;
    run_op(3'b011, 32'd9, 32'd0, lat, busy_low);
    divz_at_done = bus_if.divz;
    $display("[divzero] hi=%h lo=%h lat=%0d divz=%b", bus_if.hi, bus_if.lo, lat, divz_at_done);
    checks++;
    if (lat != 2 || bus_if.hi !== 32'd9 || bus_if.lo !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL divzero_fast: lat=%0d hi=%h lo=%h expected 2/00000009/ffffffff",
               lat, bus_if.hi, bus_if.lo);
    end
    checks++;
    if (divz_at_done !== 1'b1) begin
      failures++;
      $display("FAIL divzero_flag: divz=%b expected 1", divz_at_done);
    end
    step();
    checks++;
    if (bus_if.divz !== 1'b0) begin
      failures++;
      $display("FAIL divzero_pulse: divz=%b expected 0", bus_if.divz);
    end
`else
    test_arith("divu_zero", 3'b011, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 33);
`endif
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.op     = 3'b000;
    bus_if.busA   = 32'h0;
    bus_if.busB   = 32'h0;
    bus_if.rd_req = 1'b0;

    test_reset();
    test_arith("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    test_arith("mult_neg",  3'b000, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 33);
    test_arith("div_neg",   3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    test_arith("divu",      3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    test_arith("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
    test_mthi_mtlo();
    test_start_while_busy();
    test_mid_reset();
    test_divzero();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
